// File: rtl/rnn_weight_pkg.sv
// ---------------------------------------------------------------------------
// rnn_weight_pkg
// Shared definitions for the LSTM weight column streamer:
//   - state_t      : streamer FSM states (IDLE, STREAM)
//   - DEF_*        : default matrix geometry and count
//   - clog2_min1() : index width needed to address n entries (never below 1)
// ---------------------------------------------------------------------------
package rnn_weight_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int DEF_BITWIDTH = 18;
    localparam int DEF_NROW     = 16;
    localparam int DEF_NCOL     = 16;
    localparam int DEF_NMAT     = 4;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// ---------------------------------------------------------------------------
// weight_bank
// One NROW x NCOL weight matrix. Single-element write, full-column
// combinational read (the caller owns the output register).
// Ports:
//   clk        rising-edge clock
//   i_wr_en    write i_wr_data to (i_wr_row, i_wr_col) at this edge
//   i_wr_row   target row    (values >= NROW are dropped)
//   i_wr_col   target column (values >= NCOL are dropped)
//   i_wr_data  weight value
//   i_rd_col   column to read; must be < NCOL when the result is used
//   o_rd_word  column word, row i at [i*BITWIDTH +: BITWIDTH]
// ---------------------------------------------------------------------------
module weight_bank
    import rnn_weight_pkg::*;
#(
    parameter int NROW          = DEF_NROW,
    parameter int NCOL          = DEF_NCOL,
    parameter int BITWIDTH      = DEF_BITWIDTH,
    parameter int ADDR_BITWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [ADDR_BITWIDTH-1:0] i_wr_row,
    input  logic [ADDR_BITWIDTH-1:0] i_wr_col,
    input  logic [BITWIDTH-1:0]      i_wr_data,
    input  logic [ADDR_BITWIDTH-1:0] i_rd_col,
    output logic [NROW*BITWIDTH-1:0] o_rd_word
);

    // Storage index widths; the address ports may be wider so that
    // out-of-range addresses can be presented and rejected.
    localparam int ROW_W = clog2_min1(NROW);
    localparam int COL_W = clog2_min1(NCOL);

    logic [BITWIDTH-1:0] r_mem [NROW][NCOL];

    logic w_wr_ok;
    logic [ROW_W-1:0] w_wr_row_idx;
    logic [COL_W-1:0] w_wr_col_idx;
    logic [COL_W-1:0] w_rd_col_idx;

    // Range check on the full-width address, before truncation, so that
    // e.g. row 16 cannot alias row 0.
    assign w_wr_ok      = i_wr_en && (32'(i_wr_row) < NROW) && (32'(i_wr_col) < NCOL);
    assign w_wr_row_idx = i_wr_row[ROW_W-1:0];
    assign w_wr_col_idx = i_wr_col[COL_W-1:0];
    assign w_rd_col_idx = i_rd_col[COL_W-1:0];

    // No reset: weights survive a streamer reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_row_idx][w_wr_col_idx] <= i_wr_data;
        end
    end

    // Combinational read of the pre-edge contents gives read-before-write
    // when a write and an output-register load hit the same element.
    genvar gi;
    generate
        for (gi = 0; gi < NROW; gi++) begin : g_row
            assign o_rd_word[gi*BITWIDTH +: BITWIDTH] = r_mem[gi][w_rd_col_idx];
        end
    endgenerate

endmodule

// File: rtl/weight_column_streamer.sv
// ---------------------------------------------------------------------------
// weight_column_streamer
// Holds NMAT weight matrices and streams every column of a selected matrix,
// one row-parallel word per cycle, under a valid/ready handshake.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset (RAM contents are kept)
//   wrEnable   write one weight this cycle (any state)
//   wrMatrix   target matrix (>= NMAT dropped)
//   wrRow      target row    (>= NROW dropped)
//   wrCol      target column (>= NCOL dropped)
//   wrData     weight value
//   start      begin a stream of matSelect; honoured in IDLE only
//   matSelect  matrix to stream (>= NMAT streams all-zero columns)
//   busy       stream in progress
//   colValid   rowOutput/colIndex/colLast valid
//   colReady   consumer accepts the current column
//   colIndex   column number of the current word
//   colLast    current word is column NCOL-1
//   rowOutput  row i weight at [i*BITWIDTH +: BITWIDTH]
// ---------------------------------------------------------------------------
module weight_column_streamer
    import rnn_weight_pkg::*;
#(
    parameter int NROW             = DEF_NROW,
    parameter int NCOL             = DEF_NCOL,
    parameter int BITWIDTH         = DEF_BITWIDTH,
    parameter int NMAT             = DEF_NMAT,
    parameter int ADDR_BITWIDTH    = 4,
    parameter int MAT_BITWIDTH     = 2,
    parameter int OUTPUT_PORT_SIZE = BITWIDTH*NROW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wrEnable,
    input  logic [MAT_BITWIDTH-1:0]     wrMatrix,
    input  logic [ADDR_BITWIDTH-1:0]    wrRow,
    input  logic [ADDR_BITWIDTH-1:0]    wrCol,
    input  logic [BITWIDTH-1:0]         wrData,
    input  logic                        start,
    input  logic [MAT_BITWIDTH-1:0]     matSelect,
    output logic                        busy,
    output logic                        colValid,
    input  logic                        colReady,
    output logic [ADDR_BITWIDTH-1:0]    colIndex,
    output logic                        colLast,
    output logic [OUTPUT_PORT_SIZE-1:0] rowOutput
);

    state_t r_state;
    state_t w_state_next;

    logic [MAT_BITWIDTH-1:0]     r_cur_mat;
    // One bit wider than a column address so "all columns loaded" (NCOL)
    // is representable even when NCOL == 2^ADDR_BITWIDTH.
    logic [ADDR_BITWIDTH:0]      r_rd_col;
    logic                        r_col_valid;
    logic                        r_col_last;
    logic [ADDR_BITWIDTH-1:0]    r_col_index;
    logic [OUTPUT_PORT_SIZE-1:0] r_row_output;

    logic [OUTPUT_PORT_SIZE-1:0] w_bank_word [NMAT];
    logic [OUTPUT_PORT_SIZE-1:0] w_col_word;
    logic [MAT_BITWIDTH-1:0]     w_rd_mat;
    logic [ADDR_BITWIDTH-1:0]    w_rd_col;
    logic                        w_xfer;
    logic                        w_load;

    // In IDLE the read path looks at matSelect/column 0 so that an accepted
    // start loads column 0 at the same edge.
    assign w_rd_mat = (r_state == IDLE) ? matSelect : r_cur_mat;
    assign w_rd_col = (r_state == IDLE) ? '0 : r_rd_col[ADDR_BITWIDTH-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NMAT; gi++) begin : g_bank
            weight_bank #(
                .NROW          (NROW),
                .NCOL          (NCOL),
                .BITWIDTH      (BITWIDTH),
                .ADDR_BITWIDTH (ADDR_BITWIDTH)
            ) u_bank (
                .clk       (clk),
                .i_wr_en   (wrEnable && (32'(wrMatrix) == gi)),
                .i_wr_row  (wrRow),
                .i_wr_col  (wrCol),
                .i_wr_data (wrData),
                .i_rd_col  (w_rd_col),
                .o_rd_word (w_bank_word[gi])
            );
        end
    endgenerate

    // Matrix mux; unmatched (out-of-range) selects yield an all-zero column.
    always_comb begin
        w_col_word = '0;
        for (int m = 0; m < NMAT; m++) begin
            if (32'(w_rd_mat) == m) begin
                w_col_word = w_bank_word[m];
            end
        end
    end

    assign w_xfer = r_col_valid && colReady;
    // Refill whenever the register is empty or being drained, until every
    // column has been loaded once.
    assign w_load = (r_state == STREAM) && (!r_col_valid || colReady)
                    && (32'(r_rd_col) < NCOL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                if (w_xfer && r_col_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_mat    <= '0;
            r_rd_col     <= '0;
            r_col_valid  <= 1'b0;
            r_col_last   <= 1'b0;
            r_col_index  <= '0;
            r_row_output <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cur_mat    <= matSelect;
                        r_row_output <= w_col_word;
                        r_col_index  <= '0;
                        r_col_last   <= (NCOL == 1);
                        r_col_valid  <= 1'b1;
                        r_rd_col     <= (ADDR_BITWIDTH+1)'(1);
                    end
                end
                STREAM: begin
                    if (w_xfer && r_col_last) begin
                        r_col_valid <= 1'b0;
                    end else if (w_load) begin
                        r_row_output <= w_col_word;
                        r_col_index  <= r_rd_col[ADDR_BITWIDTH-1:0];
                        r_col_last   <= (32'(r_rd_col) == NCOL - 1);
                        r_col_valid  <= 1'b1;
                        r_rd_col     <= r_rd_col + 1'b1;
                    end else if (w_xfer) begin
                        r_col_valid <= 1'b0;
                    end
                end
                default: begin
                    r_col_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (r_state == STREAM);
    assign colValid  = r_col_valid;
    assign colIndex  = r_col_index;
    assign colLast   = r_col_last;
    assign rowOutput = r_row_output;

endmodule

// File: tb/tb_weight_column_streamer.sv
module tb_weight_column_streamer;

    localparam int NROW = 16;
    localparam int NCOL = 16;
    localparam int BW   = 18;
    localparam int NMAT = 4;
    localparam int AW   = 5;
    localparam int MW   = 3;
    localparam int OW   = BW*NROW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wrEnable;
    logic [MW-1:0] wrMatrix;
    logic [AW-1:0] wrRow;
    logic [AW-1:0] wrCol;
    logic [BW-1:0] wrData;
    logic          start;
    logic [MW-1:0] matSelect;
    logic          busy;
    logic          colValid;
    logic          colReady;
    logic [AW-1:0] colIndex;
    logic          colLast;
    logic [OW-1:0] rowOutput;

    int total = 0;
    int bad   = 0;
    int mdl [NMAT][NROW][NCOL];
    bit coll_done = 0;

    weight_column_streamer #(
        .NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW), .NMAT(NMAT),
        .ADDR_BITWIDTH(AW), .MAT_BITWIDTH(MW), .OUTPUT_PORT_SIZE(OW)
    ) dut (
        .clk(clk), .reset(reset), .wrEnable(wrEnable), .wrMatrix(wrMatrix),
        .wrRow(wrRow), .wrCol(wrCol), .wrData(wrData), .start(start),
        .matSelect(matSelect), .busy(busy), .colValid(colValid),
        .colReady(colReady), .colIndex(colIndex), .colLast(colLast),
        .rowOutput(rowOutput)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] exp_col(input int m, input int c);
        logic [OW-1:0] w;
        w = '0;
        if (m < NMAT) begin
            for (int r = 0; r < NROW; r++) begin
                w[r*BW +: BW] = BW'(mdl[m][r][c]);
            end
        end
        return w;
    endfunction

    task automatic wr(input int m, input int r, input int c, input int d);
        wrEnable = 1'b1;
        wrMatrix = MW'(m);
        wrRow    = AW'(r);
        wrCol    = AW'(c);
        wrData   = BW'(d);
        tick();
        wrEnable = 1'b0;
        if (m < NMAT && r < NROW && c < NCOL) mdl[m][r][c] = d;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"},  OW'(busy),     OW'(0));
        chk({pfx, "_valid"}, OW'(colValid), OW'(0));
        chk({pfx, "_last"},  OW'(colLast),  OW'(0));
        chk({pfx, "_index"}, OW'(colIndex), OW'(0));
        chk({pfx, "_row"},   rowOutput,     OW'(0));
    endtask

    // Streams matrix `mat`; bp selects the 1,0,0,1 ready pattern, coll plants
    // a same-edge write of 0x3FFFF to (2,0,5) when column 5 is being loaded.
    task automatic stream_check(input int mat, input bit bp, input bit coll);
        int            exp_idx;
        int            cyc;
        bit            stalled;
        logic [OW-1:0] held_row;
        logic [AW-1:0] held_idx;
        matSelect = MW'(mat);
        colReady  = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        matSelect = '0;
        chk("lat_valid", OW'(colValid), OW'(1));
        chk("lat_busy",  OW'(busy),     OW'(1));
        exp_idx = 0;
        cyc     = 0;
        stalled = 0;
        while (exp_idx < NCOL && cyc < 200) begin
            wrEnable = 1'b0;
            colReady = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (stalled) begin
                chk("stall_idx", OW'(colIndex), OW'(held_idx));
                chk("stall_row", rowOutput, held_row);
            end
            if (colValid && colReady) begin
                chk("col_idx",  OW'(colIndex), OW'(exp_idx));
                chk("col_last", OW'(colLast),  OW'(exp_idx == NCOL - 1));
                chk("col_row",  rowOutput,     exp_col(mat, exp_idx));
                if (mat == 2 && exp_idx == 7)
                    chk("spot_r3c7", OW'(rowOutput[3*BW +: BW]), OW'(55));
                if (mat == 2 && exp_idx == 5)
                    chk("coll_r0c5", OW'(rowOutput[0 +: BW]), coll_done ? OW'(18'h3FFFF) : OW'(5));
                if (coll && exp_idx == 4) begin
                    wrEnable = 1'b1;
                    wrMatrix = 3'd2;
                    wrRow    = '0;
                    wrCol    = 5'd5;
                    wrData   = 18'h3FFFF;
                end
                exp_idx++;
                stalled = 0;
            end else begin
                chk("valid_hole", OW'(colValid), OW'(1));
                stalled  = 1;
                held_row = rowOutput;
                held_idx = colIndex;
            end
            cyc++;
            tick();
        end
        wrEnable = 1'b0;
        colReady = 1'b0;
        if (exp_idx < NCOL) chk("stream_timeout", OW'(exp_idx), OW'(NCOL));
        chk("end_valid", OW'(colValid), OW'(0));
        chk("end_busy",  OW'(busy),     OW'(0));
        if (coll) begin
            mdl[2][0][5] = 18'h3FFFF;
            coll_done    = 1;
        end
        $display("stream mat=%0d bp=%0d coll=%0d cols=%0d cycles=%0d", mat, bp, coll, exp_idx, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; wrEnable = 1'b0; wrMatrix = '0; wrRow = '0; wrCol = '0;
        wrData = '0; start = 1'b0; matSelect = '0; colReady = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();

        for (int i = 0; i < NROW; i++)
            for (int j = 0; j < NCOL; j++) begin
                wr(2, i, j, 16*i + j);
                wr(1, i, j, 512 + 16*i + j);
            end

        stream_check(2, 0, 0);          // basic stream
        stream_check(1, 0, 0);          // back-to-back, start right after last transfer
        stream_check(2, 1, 0);          // backpressure 1,0,0,1
        stream_check(2, 0, 1);          // collision: old value 5 seen
        stream_check(2, 0, 0);          // new value 0x3FFFF seen

        // Reset mid-stream at column 7
        colReady  = 1'b1;
        matSelect = 3'd2;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int k = 0; k < 40 && colIndex != 5'd7; k++) tick();
        chk("reach_col7", OW'(colIndex), OW'(7));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        colReady = 1'b0;
        check_reset_outputs("midrst");
        $display("reset mid-stream at col 7");
        tick();
        stream_check(2, 0, 0);

        // Out-of-range matrix select streams zeros
        stream_check(5, 0, 0);

        // Out-of-range writes must not land anywhere
        wr(2, 16, 0, 18'h12345);
        wr(2, 0, 16, 18'h12345);
        wr(4, 0, 0, 18'h12345);
        $display("out-of-range writes issued");
        stream_check(2, 0, 0);
        stream_check(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
